// File: rtl/kw11p_timer.sv
// KW11-P programmable real-time clock with a Wishbone slave port and vectored interrupt.
// Optional external count input is built only when KW11P_EXT_EN is defined.
`timescale 1ns/1ps
module kw11p_timer #(
   parameter int unsigned CLK_HZ = 50000000,
   parameter logic [8:0]  VEC    = 9'o104
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n,
   input  logic [1:0]  wb_adr_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic        wb_we_i,
   input  logic [1:0]  wb_sel_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   input  logic        line_tick,
   input  logic        ext_clk,
   output logic        irq_o,
   input  logic        istb_i,
   output logic [8:0]  ivec_o,
   output logic        iack_o
);

   localparam int unsigned DIV = CLK_HZ / 100000;
   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   typedef enum logic [1:0] {
      RATE_100K = 2'b00,
      RATE_10K  = 2'b01,
      RATE_LINE = 2'b10,
      RATE_EXT  = 2'b11
   } rate_t;

   logic          rst_meta, rst_n;
   logic          run, rpt, up, ie, done, err;
   rate_t         rate;
   logic [15:0]   csb, ctr, csr_val, ctr_step;
   logic [PW-1:0] pre;
   logic [3:0]    dec;
   logic          line_q;
   logic          bus, wr_csr, wr_csb, wr_ctr, rd_csr, go, ie_lane;
   logic          tick100, tick10, line_pulse, ext_pulse, rate_tick, tick, evt;

   function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                              input logic [15:0] new_v,
                                              input logic [1:0]  sel);
      return {sel[1] ? new_v[15:8] : old_v[15:8], sel[0] ? new_v[7:0] : old_v[7:0]};
   endfunction

   // Reset asserts immediately but is released only on a clock edge.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   assign bus     = wb_cyc_i & wb_stb_i & wb_ack_o;
   assign wr_csr  = bus & wb_we_i & (wb_adr_i == 2'd0);
   assign wr_csb  = bus & wb_we_i & (wb_adr_i == 2'd1);
   assign wr_ctr  = bus & wb_we_i & (wb_adr_i == 2'd2);
   assign rd_csr  = bus & ~wb_we_i & (wb_adr_i == 2'd0);
   assign ie_lane = wr_csr & wb_sel_i[0];
   assign go      = ie_lane & wb_dat_i[5];

   assign csr_val = {err, 7'b0, done, ie, 1'b0, up, rpt, rate, run};

   always_comb begin
      wb_dat_o = 16'h0000;
      if (wb_stb_i) begin
         case (wb_adr_i)
            2'd0:    wb_dat_o = csr_val;
            2'd1:    wb_dat_o = csb;
            2'd2:    wb_dat_o = ctr;
            default: wb_dat_o = 16'h0000;
         endcase
      end
   end

   assign tick100    = (pre == PMAX);
   assign tick10     = tick100 & (dec == 4'd9);
   assign line_pulse = line_tick & ~line_q;

`ifdef KW11P_EXT_EN
   logic [2:0] ext_sh;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) ext_sh <= 3'b000;
      else        ext_sh <= {ext_sh[1:0], ext_clk};
   end

   assign ext_pulse = ext_sh[1] & ~ext_sh[2];
`else
   logic unused_ext;
   assign unused_ext = ext_clk;
   assign ext_pulse  = 1'b0;
`endif

   always_comb begin
      rate_tick = 1'b0;
      case (rate)
         RATE_100K: rate_tick = tick100;
         RATE_10K:  rate_tick = tick10;
         RATE_LINE: rate_tick = line_pulse;
         RATE_EXT:  rate_tick = ext_pulse;
         default:   rate_tick = 1'b0;
      endcase
   end

   // Any bus load of the counter beats a coincident tick, which is simply dropped.
   assign tick     = run & rate_tick & ~(wr_csb | wr_ctr | go);
   assign ctr_step = up ? ctr + 16'd1 : ctr - 16'd1;
   assign evt      = tick & (up ? (ctr == 16'hFFFF) : (ctr == 16'h0001));

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         pre    <= '0;
         dec    <= 4'd0;
         line_q <= 1'b0;
      end else begin
         line_q <= line_tick;
         pre    <= tick100 ? '0 : pre + 1'b1;
         if (tick100) dec <= (dec == 4'd9) ? 4'd0 : dec + 4'd1;
      end
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack_o <= 1'b0;
         run      <= 1'b0;
         rate     <= RATE_100K;
         rpt      <= 1'b0;
         up       <= 1'b0;
         ie       <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         csb      <= 16'h0000;
         ctr      <= 16'h0000;
         irq_o    <= 1'b0;
      end else begin
         wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;

         if (ie_lane) begin
            run  <= wb_dat_i[0];
            rate <= rate_t'(wb_dat_i[2:1]);
            rpt  <= wb_dat_i[3];
            up   <= wb_dat_i[4];
            ie   <= wb_dat_i[6];
         end else if (evt && !rpt) begin
            run <= 1'b0;
         end

         if (wr_csb) begin
            csb <= lane_merge(csb, wb_dat_i, wb_sel_i);
            ctr <= lane_merge(ctr, wb_dat_i, wb_sel_i);
         end else if (wr_ctr) begin
            ctr <= lane_merge(ctr, wb_dat_i, wb_sel_i);
         end else if (go) begin
            ctr <= csb;
         end else if (evt) begin
            ctr <= rpt ? csb : 16'h0000;
         end else if (tick) begin
            ctr <= ctr_step;
         end

         // A DONE the CPU is reading right now is consumed, so a coincident event is not an overrun.
         if (rd_csr) begin
            done <= 1'b0;
            err  <= 1'b0;
         end
         if (evt) begin
            done <= 1'b1;
            if (done && !rd_csr) err <= 1'b1;
         end

         if (istb_i) irq_o <= 1'b0;
         if (ie_lane && !wb_dat_i[6]) irq_o <= 1'b0;
         if ((evt && ie) || (ie_lane && wb_dat_i[6] && !ie && done)) irq_o <= 1'b1;
      end
   end

   assign iack_o = istb_i & irq_o;
   assign ivec_o = istb_i ? VEC : 9'd0;

endmodule

// File: tb/tb_kw11p_timer.sv
// Self-checking bench for kw11p_timer: read expectations are queued when a read is issued
// and compared when the DUT acknowledges it.
`timescale 1ns/1ps
module tb_kw11p_timer;

   localparam int unsigned CLK_HZ = 1000000;

   logic        clk = 1'b0;
   logic        wb_rst_n = 1'b0;
   logic [1:0]  wb_adr_i = 2'd0;
   logic [15:0] wb_dat_i = 16'h0000;
   logic [15:0] wb_dat_o;
   logic        wb_we_i = 1'b0;
   logic [1:0]  wb_sel_i = 2'b11;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_ack_o;
   logic        line_tick = 1'b0;
   logic        ext_clk = 1'b0;
   logic        irq_o;
   logic        istb_i = 1'b0;
   logic [8:0]  ivec_o;
   logic        iack_o;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   kw11p_timer #(.CLK_HZ(CLK_HZ), .VEC(9'o104)) dut (
      .wb_clk_i (clk),
      .wb_rst_n (wb_rst_n),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_we_i  (wb_we_i),
      .wb_sel_i (wb_sel_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_ack_o (wb_ack_o),
      .line_tick(line_tick),
      .ext_clk  (ext_clk),
      .irq_o    (irq_o),
      .istb_i   (istb_i),
      .ivec_o   (ivec_o),
      .iack_o   (iack_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %06o expected %06o", tag, got, want);
      end
   endtask

   // One Wishbone transfer; holds the strobe through the acked cycle so its side effects land.
   task automatic applyStimulus(input logic we, input logic [1:0] adr,
                                input logic [15:0] dat, input logic [1:0] sel);
      bit   acked;
      exp_t e;
      acked = 1'b0;
      @(negedge clk);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      for (int i = 0; i < 8 && !acked; i++) begin
         @(posedge clk);
         #1;
         acked = wb_ack_o;
      end
      if (!we) begin
         if (sb.size() == 0) begin
            checkOutput("sb_underflow", 16'(sb.size()), 16'd1);
         end else begin
            e = sb.pop_front();
            if (acked) checkOutput(e.tag, wb_dat_o, e.val);
         end
      end
      if (!acked) checkOutput("ack_timeout", 16'(acked), 16'd1);
      @(posedge clk);
      #1;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic busWrite(input logic [1:0] adr, input logic [15:0] dat,
                           input logic [1:0] sel = 2'b11);
      applyStimulus(1'b1, adr, dat, sel);
   endtask

   task automatic busRead(input logic [1:0] adr, input logic [15:0] want, input string tag);
      sb.push_back('{tag: tag, val: want});
      applyStimulus(1'b0, adr, 16'h0000, 2'b11);
   endtask

   task automatic linePulse();
      @(negedge clk);
      line_tick = 1'b1;
      repeat (2) @(negedge clk);
      line_tick = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          n;
      bit          changed;
      logic [15:0] prev;

      // Reset state, including the synchronised release.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ack", 16'(wb_ack_o), 16'd0);
      checkOutput("rst_irq", 16'(irq_o), 16'd0);
      @(negedge clk);
      wb_rst_n = 1'b1;
      repeat (4) @(posedge clk);
      busRead(2'd0, 16'o000000, "rst_csr");
      busRead(2'd1, 16'o000000, "rst_csb");
      busRead(2'd2, 16'o000000, "rst_ctr");

      // Single-shot interval on the 100 kHz tick with interrupt.
      busWrite(2'd1, 16'd3);
      busWrite(2'd0, 16'o101);
      n = 0;
      while (!irq_o && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("t1_irq", 16'(irq_o), 16'd1);
      checkOutput("t1_latency_ok", 16'(n >= 21 && n <= 30), 16'd1);
      busRead(2'd2, 16'o000000, "t1_ctr");
      busRead(2'd0, 16'o000300, "t1_csr");
      busRead(2'd0, 16'o000100, "t1_csr_clr");
      checkOutput("t1_irq_after_read", 16'(irq_o), 16'd1);

      // Vector handshake.
      @(negedge clk);
      istb_i = 1'b1;
      #1;
      checkOutput("iv_vec", 16'(ivec_o), 16'o104);
      checkOutput("iv_iack", 16'(iack_o), 16'd1);
      @(posedge clk);
      #1;
      checkOutput("iv_irq_clr", 16'(irq_o), 16'd0);
      istb_i = 1'b0;
      #1;
      checkOutput("iv_vec_idle", 16'(ivec_o), 16'd0);
      checkOutput("iv_iack_idle", 16'(iack_o), 16'd0);

      // Repeat mode overrun: second event with DONE still set raises ERR.
      busWrite(2'd0, 16'o000);
      busWrite(2'd1, 16'd2);
      busWrite(2'd0, 16'o111);
      repeat (41) @(posedge clk);
      #1;
      checkOutput("t2_irq", 16'(irq_o), 16'd1);
      busRead(2'd0, 16'o100311, "t2_csr_err");
      busRead(2'd0, 16'o000111, "t2_csr_clr");
      busWrite(2'd0, 16'o000);
      checkOutput("t2_irq_ie_off", 16'(irq_o), 16'd0);

      // Up-count on line ticks, 177776 -> 177777 -> 0 event.
      busWrite(2'd2, 16'o177776);
      busWrite(2'd0, 16'o025);
      linePulse();
      busRead(2'd2, 16'o177777, "t3_ctr_mid");
      linePulse();
      busRead(2'd2, 16'o000000, "t3_ctr_wrap");
      checkOutput("t3_no_irq", 16'(irq_o), 16'd0);
      busWrite(2'd0, 16'o100);
      checkOutput("t3_ie_late_irq", 16'(irq_o), 16'd1);
      busWrite(2'd0, 16'o000);
      checkOutput("t3_ie_clr_irq", 16'(irq_o), 16'd0);
      busRead(2'd0, 16'o000200, "t3_csr_done");
      busRead(2'd0, 16'o000000, "t3_csr_clr");

      // Down-count from 0 wraps silently; a CTR write coincident with a tick wins.
      busWrite(2'd0, 16'o001);
      @(negedge clk);
      wb_adr_i = 2'd2;
      wb_stb_i = 1'b1;
      prev = wb_dat_o;
      n = 0;
      changed = 1'b0;
      while (!changed && n < 30) begin
         @(posedge clk);
         #1;
         n++;
         if (wb_dat_o !== prev) changed = 1'b1;
      end
      checkOutput("t4_tick_seen", 16'(changed), 16'd1);
      checkOutput("t4_wrap", wb_dat_o, 16'o177777);
      wb_stb_i = 1'b0;
      repeat (8) @(posedge clk);
      busWrite(2'd2, 16'h1234);
      busRead(2'd2, 16'h1234, "t4_ctr_hold");
      busRead(2'd0, 16'o000001, "t4_csr_no_evt");
      busWrite(2'd0, 16'o000);

      // Byte lanes and the unused word.
      busWrite(2'd1, 16'h1111);
      busWrite(2'd1, 16'hABCD, 2'b10);
      busRead(2'd1, 16'hAB11, "lane_csb");
      busRead(2'd2, 16'hAB11, "lane_ctr");
      busWrite(2'd3, 16'hFFFF);
      busRead(2'd3, 16'h0000, "adr3");

      // External count input.
      busWrite(2'd1, 16'd4);
      busWrite(2'd0, 16'o007);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ext_clk = 1'b1;
         repeat (3) @(negedge clk);
         ext_clk = 1'b0;
         repeat (3) @(negedge clk);
      end
      repeat (6) @(posedge clk);
`ifdef KW11P_EXT_EN
      busRead(2'd2, 16'd0, "t5_ctr");
      busRead(2'd0, 16'o000206, "t5_csr");
`else
      busRead(2'd2, 16'd4, "t5_ctr");
      busRead(2'd0, 16'o000007, "t5_csr");
`endif
      busWrite(2'd0, 16'o000);

      // Reset in the middle of an interval abandons it.
      busWrite(2'd1, 16'd5);
      busWrite(2'd0, 16'o101);
      repeat (15) @(posedge clk);
      @(negedge clk);
      wb_rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_irq", 16'(irq_o), 16'd0);
      repeat (3) @(negedge clk);
      wb_rst_n = 1'b1;
      repeat (4) @(posedge clk);
      busRead(2'd0, 16'o000000, "t6_csr");
      busRead(2'd1, 16'o000000, "t6_csb");
      busRead(2'd2, 16'o000000, "t6_ctr");
      repeat (80) @(posedge clk);
      #1;
      checkOutput("t6_no_irq", 16'(irq_o), 16'd0);

      checkOutput("sb_drained", 16'(sb.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
